// File: rtl/down_counter_timer_if.sv
// Load-port interface for down_counter_timer: valid/ready transfer of a start value.
interface down_counter_timer_if #(
  parameter int unsigned WIDTH = 4
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_val;

  modport master (output load_valid, output load_val, input load_ready);
  modport slave  (input load_valid, input load_val, output load_ready);
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer with valid/ready load, start/pause control and terminal-count pulse.
// Optional periodic mode: define DOWN_COUNTER_AUTO_RELOAD_EN to reload the last load value at terminal count.
module down_counter_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  down_counter_timer_if.slave load,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADED,
    S_RUN,
    S_PAUSED,
    S_DONE
  } state_t;

  localparam logic [WIDTH-1:0] ZERO = WIDTH'(0);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_busy;
  logic             r_done;
  logic             r_load_ready;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
`endif

  logic w_load_fire;

  // Ready is only high in IDLE/LOADED/DONE, so a transfer always wins over start.
  assign w_load_fire = load.load_valid && r_load_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_count      <= ZERO;
      r_tc         <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_load_ready <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload     <= ZERO;
`endif
    end else begin
      r_tc <= 1'b0;
      if (w_load_fire) begin
        r_state      <= S_LOADED;
        r_count      <= load.load_val;
        r_busy       <= 1'b0;
        r_done       <= 1'b0;
        r_load_ready <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        r_reload     <= load.load_val;
`endif
      end else begin
        case (r_state)
          S_LOADED: begin
            if (start) begin
              if (r_count != ZERO) begin
                r_state      <= S_RUN;
                r_busy       <= 1'b1;
                r_load_ready <= 1'b0;
              end else begin
                r_state      <= S_DONE;
                r_tc         <= 1'b1;
                r_done       <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (pause) begin
              r_state <= S_PAUSED;
            end else if (r_count == ONE) begin
              r_tc <= 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              r_count <= r_reload;
`else
              r_count      <= ZERO;
              r_state      <= S_DONE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_load_ready <= 1'b1;
`endif
            end else if (r_count != ZERO) begin
              r_count <= r_count - ONE;
            end else begin
              // Unreachable guard: never decrement through zero.
              r_state      <= S_DONE;
              r_busy       <= 1'b0;
              r_done       <= 1'b1;
              r_load_ready <= 1'b1;
            end
          end
          S_PAUSED: begin
            if (!pause) begin
              r_state <= S_RUN;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign load.load_ready = r_load_ready;
  assign count           = r_count;
  assign tc              = r_tc;
  assign busy            = r_busy;
  assign done            = r_done;

endmodule

// File: tb/tb_down_counter_timer.sv
// Scoreboard bench for down_counter_timer: stimulus queues expected snapshots, a negedge monitor checks them.
module tb_down_counter_timer;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pause;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       done;

  down_counter_timer_if #(.WIDTH(4)) u_if ();

  down_counter_timer #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .load  (u_if),
    .start (start),
    .pause (pause),
    .count (count),
    .tc    (tc),
    .busy  (busy),
    .done  (done)
  );

  typedef struct {
    int         id;
    logic [3:0] cnt;
    logic       tc;
    logic       busy;
    logic       done;
    logic       rdy;
  } snap_t;

  snap_t exp_q[$];
  int    total = 0;
  int    bad   = 0;
  int    step  = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic snap_t mk(input logic [3:0] c, input logic t, input logic b,
                               input logic d, input logic r);
    snap_t s;
    s.id   = 0;
    s.cnt  = c;
    s.tc   = t;
    s.busy = b;
    s.done = d;
    s.rdy  = r;
    return s;
  endfunction

  task automatic cmp(input string name, input snap_t e);
    total++;
    if (count !== e.cnt || tc !== e.tc || busy !== e.busy || done !== e.done ||
        u_if.load_ready !== e.rdy) begin
      bad++;
      $display("FAIL %s: got cnt=%0d tc=%b busy=%b done=%b rdy=%b, want cnt=%0d tc=%b busy=%b done=%b rdy=%b",
               name, count, tc, busy, done, u_if.load_ready, e.cnt, e.tc, e.busy, e.done, e.rdy);
    end
  endtask

  // One clock of stimulus; expected post-edge outputs go to the scoreboard.
  task automatic cyc(input logic lv, input logic [3:0] v, input logic st, input logic pa,
                     input snap_t e);
    snap_t s;
    u_if.load_valid = lv;
    u_if.load_val   = v;
    start           = st;
    pause           = pa;
    @(posedge clk);
    s    = e;
    step++;
    s.id = step;
    exp_q.push_back(s);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      snap_t e;
      e = exp_q.pop_front();
      cmp($sformatf("step%0d", e.id), e);
    end
  end

  snap_t IDLE0;

  initial begin
    IDLE0 = mk(4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    u_if.load_valid = 1'b0;
    u_if.load_val = 4'd0;
    #1;
    cmp("reset", IDLE0);
    @(negedge clk);
    rst = 1'b0;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // Periodic mode: 2,1,2,1 with tc on each reload, done never set.
    cyc(1, 4'd2, 0, 0, mk(4'd2, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, mk(4'd2, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd1, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd2, 1, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd1, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd2, 1, 1, 0, 0));
    cyc(0, 4'd0, 0, 1, mk(4'd2, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd2, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd1, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd2, 1, 1, 0, 0));
    rst = 1'b1;
    #1;
    cmp("ar_async_rst", IDLE0);
    cyc(0, 4'd0, 0, 0, IDLE0);
    rst = 1'b0;
    cyc(1, 4'd0, 0, 0, mk(4'd0, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, mk(4'd0, 1, 0, 1, 1));
    cyc(0, 4'd0, 0, 0, mk(4'd0, 0, 0, 1, 1));
`else
    // Load 3, start, count 3,2,1,0 with tc at 0.
    cyc(1, 4'd3, 0, 0, mk(4'd3, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, mk(4'd3, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd2, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd1, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd0, 1, 0, 1, 1));
    cyc(0, 4'd0, 1, 0, mk(4'd0, 0, 0, 1, 1));
    // Load 5 with one paused edge at 3: tc two cycles later than unpaused.
    cyc(1, 4'd5, 0, 0, mk(4'd5, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, mk(4'd5, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd4, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd3, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 1, mk(4'd3, 0, 1, 0, 0));
    cyc(0, 4'd0, 1, 0, mk(4'd3, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd2, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd1, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd0, 1, 0, 1, 1));
    // Load 0, start: straight to DONE, no underflow.
    cyc(1, 4'd0, 0, 0, mk(4'd0, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, mk(4'd0, 1, 0, 1, 1));
    cyc(0, 4'd0, 0, 0, mk(4'd0, 0, 0, 1, 1));
    cyc(0, 4'd0, 0, 0, mk(4'd0, 0, 0, 1, 1));
    // Load beats start in LOADED; load in RUN ignored.
    cyc(1, 4'd7, 0, 0, mk(4'd7, 0, 0, 0, 1));
    cyc(1, 4'd9, 1, 0, mk(4'd9, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, mk(4'd9, 0, 1, 0, 0));
    cyc(1, 4'd2, 0, 0, mk(4'd8, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd7, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd6, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd5, 0, 1, 0, 0));
    // Async reset mid-RUN at count 5, visible before the next edge.
    rst = 1'b1;
    #1;
    cmp("async_rst", IDLE0);
    cyc(0, 4'd0, 0, 0, IDLE0);
    rst = 1'b0;
    cyc(0, 4'd0, 1, 0, IDLE0);
    cyc(1, 4'd1, 0, 0, mk(4'd1, 0, 0, 0, 1));
    cyc(0, 4'd0, 1, 0, mk(4'd1, 0, 1, 0, 0));
    cyc(0, 4'd0, 0, 0, mk(4'd0, 1, 0, 1, 1));
`endif

    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
